// File: rtl/dmem_sized_if.sv
// dmem_sized_if: request/response bundle between the memory stage and dmem_sized.
//
// Handshake: a request transfers on a rising clock edge when req && ready.
// req is a plain qualifier and may be asserted on consecutive cycles; every
// accepted request produces exactly one of: nothing (good store), an rvalid
// pulse (good load) or an err pulse (rejected request), one cycle after
// acceptance. ready never depends combinationally on req.
interface dmem_sized_if #(
    parameter int ADDR_W = 32
) ();
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wd;
    logic              ready;
    logic              rvalid;
    logic [31:0]       rd;
    logic              err;

    modport master (
        output req, we, size, uns, addr, wd,
        input  ready, rvalid, rd, err
    );

    modport slave (
        input  req, we, size, uns, addr, wd,
        output ready, rvalid, rd, err
    );
endinterface

// File: rtl/dmem_sized.sv
// dmem_sized: parametrised single-port data memory with byte/halfword/word
// stores, signed/unsigned sub-word loads, a one-cycle registered read and
// misalignment/range error reporting.
//
// Optional feature macro: DMEM_CLEAR_EN builds a post-reset clear sequencer
// that zeroes every word before the first request is accepted. Without it the
// block is ready straight out of reset and contents start undefined.
module dmem_sized #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    dmem_sized_if.slave bus,
    output logic        state_dbg
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(4 * DEPTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] mem [DEPTH];

    logic          accept;
    logic          bad;
    logic          oor;
    logic [AW-1:0] widx;
    logic [1:0]    lane;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   word;
    logic [7:0]    bsel;
    logic [15:0]   hsel;
    logic [31:0]   ldata;

`ifdef DMEM_CLEAR_EN
    state_t        state_nx;
    logic [AW-1:0] idx;

    // State register and clear-sweep counter; reset restarts the sweep at word 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_CLEAR;
            idx   <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_CLEAR) idx <= idx + 1'b1;
        end
    end

    // Next state: leave CLEAR on the edge that zeroes the last word.
    always_comb begin
        state_nx = state;
        case (state)
            ST_CLEAR: if (idx == AW'(DEPTH - 1)) state_nx = ST_IDLE;
            default:  state_nx = state;
        endcase
    end
`else
    assign state = ST_IDLE;
`endif

    assign state_dbg = state;
    assign bus.ready = (state == ST_IDLE);
    assign accept    = bus.req && bus.ready;
    assign widx      = bus.addr[AW+1:2];
    assign lane      = bus.addr[1:0];
    assign oor       = ({1'b0, bus.addr} >= LIMIT);

    // Reject illegal sizes, misaligned sub-words and out-of-range addresses.
    always_comb begin
        bad = oor;
        case (bus.size)
            2'b00:   bad = oor;
            2'b01:   if (lane[0]) bad = 1'b1;
            2'b10:   if (lane != 2'b00) bad = 1'b1;
            default: bad = 1'b1;
        endcase
    end

    // Byte-lane enables and lane-replicated store data.
    always_comb begin
        be    = 4'b1111;
        wdata = bus.wd;
        case (bus.size)
            2'b00: begin
                be    = 4'b0001 << lane;
                wdata = {4{bus.wd[7:0]}};
            end
            2'b01: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{bus.wd[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = bus.wd;
            end
        endcase
    end

    // Load path: pick the addressed byte/halfword, shift to bit 0 and extend.
    always_comb begin
        word  = mem[widx];
        bsel  = word[{lane, 3'b000} +: 8];
        hsel  = word[{lane[1], 4'b0000} +: 16];
        ldata = word;
        case (bus.size)
            2'b00:   ldata = bus.uns ? {24'h0, bsel} : {{24{bsel[7]}}, bsel};
            2'b01:   ldata = bus.uns ? {16'h0, hsel} : {{16{hsel[15]}}, hsel};
            default: ldata = word;
        endcase
    end

    // Array writes: clear sweep while sequencing, otherwise lane-masked stores.
    always_ff @(posedge clock) begin
`ifdef DMEM_CLEAR_EN
        if (state == ST_CLEAR) begin
            mem[idx] <= '0;
        end else
`endif
        if (accept && bus.we && !bad) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Response registers: one-cycle rvalid/err pulses, rd holds between loads.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.rvalid <= 1'b0;
            bus.err    <= 1'b0;
            bus.rd     <= '0;
        end else begin
            bus.rvalid <= accept && !bus.we && !bad;
            bus.err    <= accept && bad;
            if (accept && !bus.we && !bad) bus.rd <= ldata;
        end
    end
endmodule

// File: tb/tb_dmem_sized.sv
// tb_dmem_sized: self-checking bench for dmem_sized (DEPTH=64). Works with or
// without DMEM_CLEAR_EN defined.
module tb_dmem_sized;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 32;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic state_dbg;

    int total = 0;
    int bad   = 0;

    // bit 32 = expect err, bits 31:0 = expected load data
    logic [32:0] exp_q[$];
    logic [31:0] last_exp = '0;
    logic [7:0]  mb [4*DEPTH];

    // clock / reset block
    always #5 clock = ~clock;

    dmem_sized_if #(.ADDR_W(ADDR_W)) bus ();

    dmem_sized #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .bus      (bus),
        .state_dbg(state_dbg)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h want=%08h", tag, got, exp);
        end
    endtask

    // scoreboard: runs at every negedge, pops one entry per DUT response
    task automatic sample();
        logic [32:0] e;
        if (!reset_n) last_exp = '0;
        if (bus.rvalid || bus.err) begin
            check("excl", {31'h0, bus.rvalid & bus.err}, 32'h0);
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("resp_kind", {31'h0, bus.err}, {31'h0, e[32]});
                if (!e[32]) begin
                    check("rd", bus.rd, e[31:0]);
                    last_exp = e[31:0];
                end else begin
                    check("rd_hold", bus.rd, last_exp);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        sample();
    endtask

    // driver: called at a negedge, request is accepted on the next posedge
    task automatic issue(input logic w, input logic [1:0] s, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic exp_err, input logic [31:0] exp_rd);
        check("ready", {31'h0, bus.ready}, 32'h1);
        bus.req  = 1'b1;
        bus.we   = w;
        bus.size = s;
        bus.uns  = u;
        bus.addr = a;
        bus.wd   = d;
        if (exp_err) exp_q.push_back({1'b1, 32'h0});
        else if (!w) exp_q.push_back({1'b0, exp_rd});
        tick();
        bus.req = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (n < 200) begin
            tick();
            n++;
            if (bus.ready) break;
        end
    endtask

    task automatic do_reset();
        bus.req  = 1'b0;
        bus.we   = 1'b0;
        bus.size = 2'b00;
        bus.uns  = 1'b0;
        bus.addr = '0;
        bus.wd   = '0;
        reset_n  = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_rvalid", {31'h0, bus.rvalid}, 32'h0);
        check("rst_err", {31'h0, bus.err}, 32'h0);
        check("rst_rd", bus.rd, 32'h0);
`ifdef DMEM_CLEAR_EN
        check("rst_ready", {31'h0, bus.ready}, 32'h0);
`else
        check("rst_ready", {31'h0, bus.ready}, 32'h1);
`endif
        reset_n = 1'b1;
    endtask

    task automatic after_reset();
        int n;
`ifdef DMEM_CLEAR_EN
        wait_ready(n);
        check("clear_len", n, DEPTH);
`else
        tick();
        n = 0;
`endif
    endtask

    // byte-array reference model
    task automatic mstore(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        int b;
        b = int'(a[7:0]);
        mb[b] = d[7:0];
        if (s != 2'b00) mb[b+1] = d[15:8];
        if (s == 2'b10) begin
            mb[b+2] = d[23:16];
            mb[b+3] = d[31:24];
        end
    endtask

    function automatic logic [31:0] mload(input logic [1:0] s, input logic u, input logic [31:0] a);
        int b;
        logic [31:0] r;
        b = int'(a[7:0]);
        if (s == 2'b00) r = u ? {24'h0, mb[b]} : {{24{mb[b][7]}}, mb[b]};
        else if (s == 2'b01) r = u ? {16'h0, mb[b+1], mb[b]} : {{16{mb[b+1][7]}}, mb[b+1], mb[b]};
        else r = {mb[b+3], mb[b+2], mb[b+1], mb[b]};
        return r;
    endfunction

    initial begin
        logic [1:0]  s;
        logic [31:0] a;
        logic [31:0] d;
        logic        u;
        int          n;

        do_reset();
        after_reset();

`ifdef DMEM_CLEAR_EN
        issue(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 1'b0, 32'h0000_0000);
        issue(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, 1'b0, 32'h0000_0000);
`endif

        // read-after-write with a byte merge, back-to-back
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 1'b0, 32'h0);
        issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AA, 1'b0, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h1122_AA44);

        // sub-word loads with sign/zero extension
        issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_8001, 1'b0, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b0, 32'hFFFF_8001);
        issue(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b0, 32'h0000_8001);
        issue(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 1'b0, 32'hFFFF_FF80);
        issue(1'b0, 2'b00, 1'b1, 32'h22, 32'h0, 1'b0, 32'h0000_0001);

        // error cases must not touch the array or rd
        issue(1'b1, 2'b10, 1'b0, 32'h00, 32'h0BAD_BEEF, 1'b0, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 32'h04, 32'hCAFE_F00D, 1'b0, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h1122_AA44);
        issue(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 1'b1, 32'h0);
        issue(1'b1, 2'b01, 1'b0, 32'h05, 32'h0000_FFFF, 1'b1, 32'h0);
        issue(1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0);
        tick();
        check("rd_after_err", bus.rd, 32'h1122_AA44);
        issue(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 1'b0, 32'h0BAD_BEEF);
        issue(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 1'b0, 32'hCAFE_F00D);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h1122_AA44);

        // random traffic against the byte model: fill, then mix
        for (int w = 0; w < DEPTH; w++) begin
            d = $urandom;
            a = 32'(4 * w);
            mstore(2'b10, a, d);
            issue(1'b1, 2'b10, 1'b0, a, d, 1'b0, 32'h0);
        end
        for (int k = 0; k < 150; k++) begin
            s = 2'($urandom_range(0, 2));
            u = 1'($urandom_range(0, 1));
            d = $urandom;
            a = 32'(4 * $urandom_range(0, DEPTH - 1));
            if (s == 2'b00) a[1:0] = 2'($urandom_range(0, 3));
            else if (s == 2'b01) a[1] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: s = 2'b11;
                    1: begin s = 2'b01; a[0] = 1'b1; end
                    2: begin s = 2'b10; a[1:0] = 2'($urandom_range(1, 3)); end
                    default: a = 32'(4 * DEPTH + 4 * $urandom_range(0, 100));
                endcase
                issue(1'($urandom_range(0, 1)), s, u, a, d, 1'b1, 32'h0);
            end else if ($urandom_range(0, 1) == 1) begin
                mstore(s, a, d);
                issue(1'b1, s, u, a, d, 1'b0, 32'h0);
            end else begin
                issue(1'b0, s, u, a, d, 1'b0, mload(s, u, a));
            end
            if ($urandom_range(0, 3) == 0) tick();
        end
        tick();

        // store accepted on the last edge before reset survives (unless cleared)
        issue(1'b1, 2'b10, 1'b0, 32'h44, 32'h5A5A_1234, 1'b0, 32'h0);
        do_reset();
        after_reset();
`ifdef DMEM_CLEAR_EN
        issue(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 1'b0, 32'h0000_0000);
`else
        issue(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 1'b0, 32'h5A5A_1234);
`endif

        // reset between load accept and response drops rvalid and clears rd
        issue(1'b1, 2'b10, 1'b0, 32'h48, 32'hA5A5_0F0F, 1'b0, 32'h0);
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.size = 2'b10;
        bus.addr = 32'h48;
        @(posedge clock);
        #1;
        bus.req = 1'b0;
        check("pre_rst_rvalid", {31'h0, bus.rvalid}, 32'h1);
        check("pre_rst_rd", bus.rd, 32'hA5A5_0F0F);
        reset_n = 1'b0;
        #1;
        check("async_rvalid", {31'h0, bus.rvalid}, 32'h0);
        check("async_rd", bus.rd, 32'h0);
        last_exp = '0;
        @(negedge clock);
        do_reset();
        after_reset();

`ifdef DMEM_CLEAR_EN
        // reset mid-sweep restarts the full sweep
        do_reset();
        repeat (30) tick();
        check("mid_clear_ready", {31'h0, bus.ready}, 32'h0);
        do_reset();
        wait_ready(n);
        check("restart_len", n, DEPTH);
        issue(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0000_0000);
`endif

        repeat (3) tick();
        check("q_empty", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_sized.md
# dmem_sized

Parametrised single-port data memory for the MIPS datapath, replacing the fixed 64-word, word-only data memory. Supports byte, halfword and word stores through byte-lane enables; signed and unsigned sub-word loads; a one-cycle registered read with a valid strobe; and misalignment/range error reporting. An optional post-reset clear sequencer zeroes the array before the first access is accepted. It sits between the execute/memory stage and the writeback mux.

## Interface
- DEPTH, 64: number of 32-bit words; power of two, at least 4.
- ADDR_W, 32: width of the byte address input.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  access request; accepted on a rising edge when `req && ready`.
- we  in  1  1 = store, 0 = load; sampled with `req`.
- size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
- uns  in  1  1 = zero-extend sub-word loads, 0 = sign-extend; ignored for word loads and stores.
- addr  in  ADDR_W  byte address.
- wd  in  32  store data, right-aligned: byte in [7:0], halfword in [15:0].
- ready  out  1  block can accept a request this cycle.
- rvalid  out  1  one-cycle pulse; `rd` holds valid load data.
- rd  out  32  extended load data; holds its last value while `rvalid` is 0.
- err  out  1  one-cycle pulse; the accepted request was rejected.

## Operation
- Word index is `addr[log2(DEPTH)+1:2]`. Byte lane is `addr[1:0]`, little-endian: lane 0 is bits [7:0].
- Error conditions, checked on accept:
  - size = 11.
  - Halfword with `addr[0]` = 1.
  - Word with `addr[1:0]` ≠ 0.
  - `addr >= 4*DEPTH`.
- Errored request: no array write, `rvalid` stays 0, `rd` unchanged, `err` = 1 on the next cycle.
- Byte store: writes `wd[7:0]` to lane `addr[1:0]` only.
- Halfword store: writes `wd[15:0]` to lanes {2*addr[1]+1, 2*addr[1]}.
- Word store: writes all four lanes.
- Unwritten lanes are always preserved.
- Load: the selected byte or halfword is shifted to bit 0, then extended per `uns`. Word loads are returned unchanged.
- Stores produce no `rvalid`.
- One request per cycle. `ready` is 1 in IDLE and stays 1 while requests stream back-to-back.
- State machine: states CLEAR and IDLE.
  - CLEAR (only with DMEM_CLEAR_EN): a counter `idx` walks 0..DEPTH-1, writing 0x00000000 to word `idx` on each edge. `ready` = 0 throughout; `req` is ignored.
  - CLEAR → IDLE on the edge that writes word DEPTH-1.
  - IDLE is terminal until reset.
- Reset asserted mid-CLEAR: the sequencer restarts at `idx` = 0 after release. Words already cleared stay zero.
- Reset asserted mid-access: any pending `rvalid`/`err` is dropped. A store accepted on the last edge before reset is retained.

## Timing
- Reset values: `rvalid` = 0, `err` = 0, `rd` = 0, `idx` = 0.
  - With DMEM_CLEAR_EN: state = CLEAR, so `ready` = 0.
  - Without DMEM_CLEAR_EN: state = IDLE, so `ready` = 1.
- Load latency is 1: accepted on edge N, so `rvalid`/`rd` are valid in the cycle after edge N and deassert after edge N+1 unless a new load was accepted.
- `err` uses the same latency and duration as `rvalid`. `rvalid` and `err` are never both 1.
- Store accepted on edge N is visible to a load accepted on edge N+1 (read-after-write, no stall).
- The clear sweep takes exactly DEPTH cycles. The first request can be accepted on edge DEPTH+1 after reset release.
- `ready` is a registered-state decode and has no combinational path from `req`.

## Configuration
- DMEM_CLEAR_EN defined: the CLEAR state and `idx` counter are built in. Contents are all-zero when `ready` first rises.
- DMEM_CLEAR_EN undefined: no CLEAR state and no `idx` counter. `ready` is tied to 1 and array contents after reset are undefined (X in simulation).
- The macro has no other effect on behaviour or timing.

## Test plan
- Clear sweep (DMEM_CLEAR_EN, DEPTH=64) → `ready` = 0 for 64 cycles after reset release. A load of 0x00 then 0xFC returns 0x00000000 with `rvalid` one cycle after accept.
- sw 0x11223344 @0x10, then sb 0xAA @0x11, then lw @0x10 on consecutive cycles → `rd` = 0x1122AA44 one cycle after the lw.
- sh 0x8001 @0x22, then lh @0x22 → 0xFFFF8001; lhu → 0x00008001; lb @0x23 → 0xFFFFFF80; lbu @0x22 → 0x00000001.
- lw @0x02, sh @0x05, size=11, and sw @0x100 (DEPTH=64) → `err` pulses once for each, no `rvalid`, and a follow-up lw shows the array unmodified.
- Reset_n pulsed low at `idx` = 30 during CLEAR → `ready` stays 0 for a further 64 full cycles after release.
- Load accepted on edge N, then reset_n asserted before edge N+1 → `rvalid` = 0, `rd` = 0 immediately (asynchronous).
